// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: IDLE/ISSUE/CAPTURE issue controller with an 8x32 register file feeding an external ALU.
// Define ALU_ISSUE_R0_ZERO_EN to hardwire R0 to zero.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_dout,
  input  logic        alu_cout,
  output logic        done,
  output logic        illegal,
  output logic        carry_flag,
  output logic        zero_flag
);
`ifdef ALU_ISSUE_R0_ZERO_EN
  localparam logic r0_zero = 1'b1;
`else
  localparam logic r0_zero = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  state_t state, state_nx;
  logic [31:0] regs [8];
  logic [11:0] ir;
  logic [2:0] op, rd, ra, rb;
  logic legal, accept, ld_ok, wb_ok, unused_bits;
  assign {op, rd, ra, rb} = ir;
  assign legal = !(op[2] && op[1]);
  assign accept = instr_valid && instr_ready;
  assign ld_ok = state == IDLE && ld_en && !(r0_zero && ld_addr == 3'd0);
  assign wb_ok = !(r0_zero && rd == 3'd0);
  assign rd_data = (r0_zero && rd_addr == 3'd0) ? '0 : regs[rd_addr];
  assign unused_bits = ^instr[3:0];
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (accept ? ISSUE : IDLE) :
               (state == ISSUE && legal) ? CAPTURE : IDLE;
  end
  always_comb begin
    instr_ready = state == IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      ir <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= '0;
      done <= 1'b0;
      illegal <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      illegal <= 1'b0;
      if (accept) ir <= instr[15:4];
      if (ld_ok) regs[ld_addr] <= ld_data;
      if (state == ISSUE && legal) begin
        alu_a <= regs[ra];
        alu_b <= regs[rb];
        alu_ctrl <= op;
      end
      if (state == ISSUE && !legal) illegal <= 1'b1;
      // operands were captured in ISSUE, so ra/rb aliasing rd already saw the old value
      if (state == CAPTURE) begin
        if (wb_ok) regs[rd] <= alu_dout;
        zero_flag <= alu_dout == '0;
        carry_flag <= alu_ctrl[2] && !alu_ctrl[1] && alu_cout;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table-driven vectors with a scoreboard queue against a behavioural ALU.
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst, instr_valid, instr_ready, ld_en, done, illegal, carry_flag, zero_flag, alu_cout;
  logic [15:0] instr;
  logic [2:0] ld_addr, rd_addr, alu_ctrl;
  logic [31:0] ld_data, rd_data, alu_a, alu_b, alu_dout;
  logic [32:0] sum, diff;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] a_val, b_val;
    logic [2:0]  op, rd, ra, rb;
    logic [31:0] res;
    logic z, c, ill;
  } vec_t;
  typedef struct {
    logic [31:0] res;
    logic z, c, ill;
    logic [2:0] rd;
  } exp_t;
  vec_t vecs[9];
  exp_t sbq[$];

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_dout(alu_dout), .alu_cout(alu_cout),
    .done(done), .illegal(illegal), .carry_flag(carry_flag), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  // ALU: and/or/xnor/xor/add/sub; carry out reports add carry except sub reports borrow
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, alu_b};
    diff = {1'b0, alu_a} - {1'b0, alu_b};
    alu_dout = alu_ctrl == 3'd0 ? alu_a & alu_b :
               alu_ctrl == 3'd1 ? alu_a | alu_b :
               alu_ctrl == 3'd2 ? ~(alu_a ^ alu_b) :
               alu_ctrl == 3'd3 ? alu_a ^ alu_b :
               alu_ctrl == 3'd4 ? sum[31:0] :
               alu_ctrl == 3'd5 ? diff[31:0] : 32'd0;
    alu_cout = alu_ctrl == 3'd5 ? diff[32] : sum[32];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic ld(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [2:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  // ld_mode: 0 none, 1 load with the accept, 2 load held through ISSUE/CAPTURE
  task automatic do_issue(input vec_t v, input int ld_mode, input logic [2:0] la, input logic [31:0] lv);
    exp_t e;
    int k;
    logic got;
    @(negedge clk);
    chk("ready_before", instr_ready, 1);
    instr_valid = 1'b1;
    instr = {v.op, v.rd, v.ra, v.rb, 4'hA};
    ld_en = ld_mode == 1; ld_addr = la; ld_data = lv;
    sbq.push_back('{v.res, v.z, v.c, v.ill, v.rd});
    @(negedge clk);
    instr_valid = 1'b0;
    ld_en = ld_mode == 2;
    chk("no_pulse_issue", {done, illegal}, 0);
    chk("ready_busy", instr_ready, 0);
    got = 1'b0;
    k = 0;
    for (int i = 1; i <= 6 && !got; i++) begin
      @(negedge clk);
      if (i == 1 && !v.ill) begin
        chk("alu_a", alu_a, v.a_val);
        chk("alu_b", alu_b, v.b_val);
        chk("alu_ctrl", alu_ctrl, v.op);
      end
      if (done || illegal) begin
        got = 1'b1;
        k = i;
      end
    end
    ld_en = 1'b0;
    chk("pulse_seen", got, 1);
    if (got) begin
      e = sbq.pop_front();
      chk("pulse_kind", {done, illegal}, e.ill ? 2'b01 : 2'b10);
      chk("latency", k, e.ill ? 1 : 2);
      chk("zero_flag", zero_flag, e.z);
      chk("carry_flag", carry_flag, e.c);
      rdchk("result", e.rd, e.res);
    end
    @(negedge clk);
    chk("pulse_clear", {done, illegal}, 0);
    chk("ready_after", instr_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0] = '{32'd5, 32'd3, 3'b101, 3'd3, 3'd1, 3'd2, 32'd2, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'd1, 3'b100, 3'd4, 3'd1, 3'd2, 32'd0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{32'h1234, 32'h1234, 3'b110, 3'd5, 3'd5, 3'd5, 32'h1234, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b011, 3'd1, 3'd1, 3'd1, 32'd0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b000, 3'd2, 3'd6, 3'd7, 32'h00F0_000F, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h1200_0000, 32'h0000_0034, 3'b001, 3'd7, 3'd3, 3'd4, 32'h1200_0034, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'hDEAD, 32'hDEAD, 3'b111, 3'd6, 3'd6, 3'd6, 32'hDEAD, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{32'h7FFF_FFFF, 32'd1, 3'b100, 3'd5, 3'd2, 3'd3, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'd1, 32'd2, 3'b101, 3'd6, 3'd4, 3'd5, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    rst = 1'b1; instr_valid = 1'b0; ld_en = 1'b0; instr = '0;
    ld_addr = '0; ld_data = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_alu", {alu_a, alu_b} == 64'd0, 1);
    chk("rst_ctrl", alu_ctrl, 0);
    chk("rst_pulses_flags", {done, illegal, carry_flag, zero_flag}, 0);
    for (int r = 0; r < 8; r++) rdchk("rst_reg", r[2:0], 0);

    foreach (vecs[i]) begin
      ld(vecs[i].ra, vecs[i].a_val);
      ld(vecs[i].rb, vecs[i].b_val);
      do_issue(vecs[i], 0, 3'd0, 32'd0);
    end

    // load coincident with accept must be visible to the instruction
    do_issue('{32'h10, 32'h10, 3'b100, 3'd2, 3'd1, 3'd1, 32'h20, 1'b0, 1'b0, 1'b0}, 1, 3'd1, 32'h10);
    rdchk("coinc_ld", 3'd1, 32'h10);
    // loads while busy are dropped
    ld(3'd7, 32'h77);
    do_issue('{32'h10, 32'h10, 3'b100, 3'd3, 3'd1, 3'd1, 32'h20, 1'b0, 1'b0, 1'b0}, 2, 3'd7, 32'h99);
    rdchk("busy_ld_ignored", 3'd7, 32'h77);

    // reset in ISSUE aborts the instruction
    ld(3'd1, 32'd5);
    ld(3'd2, 32'd3);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {3'b100, 3'd4, 3'd1, 3'd2, 4'h0};
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || illegal) cnt++;
      @(negedge clk);
    end
    chk("abort_no_pulse", cnt, 0);
    chk("abort_alu", {alu_a, alu_b} == 64'd0, 1);
    chk("abort_ctrl", alu_ctrl, 0);
    chk("abort_flags", {carry_flag, zero_flag}, 0);
    chk("abort_ready", instr_ready, 1);
    rdchk("abort_rd", 3'd4, 0);
    rdchk("abort_r1", 3'd1, 0);

    ld(3'd0, 32'd7);
`ifdef ALU_ISSUE_R0_ZERO_EN
    rdchk("r0_ld", 3'd0, 32'd0);
`else
    rdchk("r0_ld", 3'd0, 32'd7);
`endif
    ld(3'd1, 32'h40);
    ld(3'd2, 32'h2);
`ifdef ALU_ISSUE_R0_ZERO_EN
    do_issue('{32'h40, 32'h2, 3'b001, 3'd0, 3'd1, 3'd2, 32'h0, 1'b0, 1'b0, 1'b0}, 0, 3'd0, 32'd0);
`else
    do_issue('{32'h40, 32'h2, 3'b001, 3'd0, 3'd1, 3'd2, 32'h42, 1'b0, 1'b0, 1'b0}, 0, 3'd0, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
